// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive-side blocks: data width, handshake
// FSM encoding and the reset polarity used by every register in this slice.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  // All UART-side registers reset asynchronously on a high rst.
  localparam logic RST_ACTIVE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CLEAR    = 2'd1,
    ST_WAIT_LOW = 2'd2
  } rx_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Show-ahead synchronous FIFO with registered occupancy flags. A write into a
// full FIFO is accepted only when a pop happens in the same cycle.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = UART_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              wr_acc,
  output logic              pop
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              empty_q, empty_d;
  logic              full_q, full_d;

  always_comb begin
    pop      = rd_en && !empty_q;
    // At full, the slot being popped is the one the write lands in.
    wr_acc   = wr_en && (!full_q || pop);
    wr_ptr_d = wr_acc ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop    ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    count_d  = count_q;
    case ({wr_acc, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    empty_d  = (count_d == '0);
    full_d   = (count_d == FULL_CNT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ACTIVE) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr_q] <= wr_data;
  end

  assign rd_data = empty_q ? '0 : mem[rd_ptr_q];
  assign empty   = empty_q;
  assign full    = full_q;
  assign count   = count_q;

endmodule

// File: rtl/uart_rx_drain.sv
// Drains completed bytes from the UART receiver into a FIFO, clearing the
// receiver's ready flag with a one-cycle pulse and flagging dropped bytes.
module uart_rx_drain
  import uart_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx_rdy,
  input  logic [UART_DATA_W-1:0] rx_data,
  output logic                   rx_rdy_clr,
  input  logic                   rd_en,
  output logic [UART_DATA_W-1:0] dout,
  output logic                   empty,
  output logic                   full,
  output logic [ADDR_W:0]        count,
  output logic                   overrun,
  input  logic                   clr_overrun
);

  rx_state_e state_q, state_d;
  logic      clr_q, clr_d;
  logic      overrun_q, overrun_d;
  logic      cap;
  logic      wr_acc;
  logic      pop;

  always_comb begin
    state_d = state_q;
    clr_d   = 1'b0;
    cap     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rx_rdy) begin
          cap     = 1'b1;
          clr_d   = 1'b1;
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR:    state_d = ST_WAIT_LOW;
      // Holding here until rx_rdy drops keeps one assertion from being captured twice.
      ST_WAIT_LOW: if (!rx_rdy) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    overrun_d = overrun_q | (cap && !wr_acc);
    if (clr_overrun) overrun_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ACTIVE) begin
      state_q   <= ST_IDLE;
      clr_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_q     <= clr_d;
      overrun_q <= overrun_d;
    end
  end

  uart_sync_fifo #(
    .ADDR_W (ADDR_W),
    .DATA_W (UART_DATA_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (cap),
    .wr_data (rx_data),
    .rd_en   (rd_en),
    .rd_data (dout),
    .empty   (empty),
    .full    (full),
    .count   (count),
    .wr_acc  (wr_acc),
    .pop     (pop)
  );

  assign rx_rdy_clr = clr_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_drain.sv
// Randomized bench for uart_rx_drain: a receiver model drives the handshake and
// a byte queue predicts FIFO contents, flags and overrun.
module tb_uart_rx_drain;

  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx_rdy;
  logic [7:0]    rx_data;
  logic          rx_rdy_clr;
  logic          rd_en;
  logic [7:0]    dout;
  logic          empty;
  logic          full;
  logic [AW:0]   count;
  logic          overrun;
  logic          clr_overrun;

  int            n_cmp  = 0;
  int            n_fail = 0;
  logic [7:0]    q[$];
  bit            m_ovr;

  always #5 clk = ~clk;

  uart_rx_drain #(.ADDR_W(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_rdy      (rx_rdy),
    .rx_data     (rx_data),
    .rx_rdy_clr  (rx_rdy_clr),
    .rd_en       (rd_en),
    .dout        (dout),
    .empty       (empty),
    .full        (full),
    .count       (count),
    .overrun     (overrun),
    .clr_overrun (clr_overrun)
  );

  // Receiver model: present a byte, keep rx_rdy up until cleared (plus hold
  // extra cycles), then drop it. Optional pop / overrun clear in capture cycle.
  task automatic send(input logic [7:0] b, input bit pop_too, input bit clr_ov, input int hold);
    int         n;
    bit         pf;
    logic [7:0] head;
    logic [AW:0] ec;
    @(negedge clk);
    head = (q.size() > 0) ? q[0] : 8'h00;
    n_cmp++; if (dout !== head) begin n_fail++; $display("FAIL send_head: dout=%h exp=%h", dout, head); end
    rx_rdy = 1'b1; rx_data = b; rd_en = pop_too; clr_overrun = clr_ov;
    pf = pop_too && (q.size() > 0);
    if (q.size() < DEPTH || pf) begin
      if (pf) q.delete(0);
      q.push_back(b);
    end else m_ovr = 1'b1;
    if (clr_ov) m_ovr = 1'b0;
    n = 0;
    do begin
      @(negedge clk); rd_en = 1'b0; clr_overrun = 1'b0; n++;
    end while (rx_rdy_clr !== 1'b1 && n < 8);
    n_cmp++; if (n != 1) begin n_fail++; $display("FAIL clr_latency: cycles=%0d exp=1", n); end
    ec   = (AW+1)'(q.size());
    head = (q.size() > 0) ? q[0] : 8'h00;
    n_cmp++; if (count !== ec) begin n_fail++; $display("FAIL send_count: count=%0d exp=%0d", count, ec); end
    n_cmp++; if (empty !== (q.size() == 0)) begin n_fail++; $display("FAIL send_empty: empty=%b exp=%b", empty, q.size() == 0); end
    n_cmp++; if (full !== (q.size() == DEPTH)) begin n_fail++; $display("FAIL send_full: full=%b exp=%b", full, q.size() == DEPTH); end
    n_cmp++; if (overrun !== m_ovr) begin n_fail++; $display("FAIL send_overrun: overrun=%b exp=%b", overrun, m_ovr); end
    n_cmp++; if (dout !== head) begin n_fail++; $display("FAIL send_dout: dout=%h exp=%h", dout, head); end
    repeat (hold) begin
      @(negedge clk);
      n_cmp++; if (rx_rdy_clr !== 1'b0 || count !== ec) begin
        n_fail++; $display("FAIL hold_recapture: clr=%b count=%0d exp clr=0 count=%0d", rx_rdy_clr, count, ec);
      end
    end
    rx_rdy = 1'b0;
    @(negedge clk);
    n_cmp++; if (rx_rdy_clr !== 1'b0) begin n_fail++; $display("FAIL clr_width: clr=%b exp=0", rx_rdy_clr); end
  endtask

  task automatic pop_one();
    logic [7:0]  head;
    logic [AW:0] ec;
    @(negedge clk);
    head = (q.size() > 0) ? q[0] : 8'h00;
    n_cmp++; if (dout !== head) begin n_fail++; $display("FAIL pop_head: dout=%h exp=%h", dout, head); end
    rd_en = 1'b1;
    if (q.size() > 0) q.delete(0);
    @(negedge clk);
    rd_en = 1'b0;
    ec   = (AW+1)'(q.size());
    head = (q.size() > 0) ? q[0] : 8'h00;
    n_cmp++; if (count !== ec) begin n_fail++; $display("FAIL pop_count: count=%0d exp=%0d", count, ec); end
    n_cmp++; if (empty !== (q.size() == 0) || full !== (q.size() == DEPTH)) begin
      n_fail++; $display("FAIL pop_flags: empty=%b full=%b exp empty=%b full=%b", empty, full, q.size() == 0, q.size() == DEPTH);
    end
    n_cmp++; if (dout !== head) begin n_fail++; $display("FAIL pop_dout: dout=%h exp=%h", dout, head); end
    n_cmp++; if (overrun !== m_ovr) begin n_fail++; $display("FAIL pop_overrun: overrun=%b exp=%b", overrun, m_ovr); end
  endtask

  task automatic drain();
    while (q.size() > 0) pop_one();
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_rdy = 1'b0; rx_data = 8'h00; rd_en = 1'b0; clr_overrun = 1'b0;
    q.delete(); m_ovr = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (rx_rdy_clr !== 1'b0 || overrun !== 1'b0) begin n_fail++; $display("FAIL reset_ctl: clr=%b ovr=%b exp 0 0", rx_rdy_clr, overrun); end
    n_cmp++; if (count !== '0 || empty !== 1'b1 || full !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: count=%0d empty=%b full=%b exp 0 1 0", count, empty, full);
    end
    n_cmp++; if (dout !== 8'h00) begin n_fail++; $display("FAIL reset_dout: dout=%h exp=00", dout); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    send(8'hA5, 1'b0, 1'b0, 0);
    n_cmp++; if (dout !== 8'hA5 || count !== 5'd1) begin n_fail++; $display("FAIL single_byte: dout=%h count=%0d exp A5 1", dout, count); end
    drain();
  endtask

  task automatic test_hold_high();
    send(8'($urandom), 1'b0, 1'b0, 10);
    n_cmp++; if (count !== 5'd1) begin n_fail++; $display("FAIL hold_single: count=%0d exp=1", count); end
    drain();
  endtask

  task automatic test_full_overrun();
    for (int i = 0; i < DEPTH; i++) send(8'(i), 1'b0, 1'b0, 0);
    n_cmp++; if (full !== 1'b1 || overrun !== 1'b0) begin n_fail++; $display("FAIL fill16: full=%b ovr=%b exp 1 0", full, overrun); end
    send(8'hFF, 1'b0, 1'b0, 0);
    n_cmp++; if (overrun !== 1'b1 || count !== 5'd16) begin n_fail++; $display("FAIL drop17: ovr=%b count=%0d exp 1 16", overrun, count); end
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      n_cmp++; if (dout !== 8'(i)) begin n_fail++; $display("FAIL order: dout=%h exp=%h", dout, 8'(i)); end
      pop_one();
    end
    @(negedge clk); clr_overrun = 1'b1; m_ovr = 1'b0;
    @(negedge clk); clr_overrun = 1'b0;
    n_cmp++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL clr_overrun: ovr=%b exp=0", overrun); end
  endtask

  task automatic test_full_with_pop();
    logic [7:0] last;
    for (int i = 0; i < DEPTH; i++) send(8'(i), 1'b0, 1'b0, 0);
    send(8'h55, 1'b1, 1'b0, 0);
    n_cmp++; if (count !== 5'd16 || overrun !== 1'b0) begin n_fail++; $display("FAIL full_pop: count=%0d ovr=%b exp 16 0", count, overrun); end
    last = 8'h00;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk); last = dout;
      pop_one();
    end
    n_cmp++; if (last !== 8'h55) begin n_fail++; $display("FAIL full_pop_last: last=%h exp=55", last); end
    // Drop and clear in the same cycle: the clear wins.
    for (int i = 0; i < DEPTH; i++) send(8'($urandom), 1'b0, 1'b0, 0);
    send(8'hEE, 1'b0, 1'b1, 0);
    n_cmp++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL clr_priority: ovr=%b exp=0", overrun); end
    drain();
  endtask

  task automatic test_empty_and_wrap();
    pop_one();
    n_cmp++; if (count !== '0 || dout !== 8'h00) begin n_fail++; $display("FAIL empty_pop: count=%0d dout=%h exp 0 00", count, dout); end
    send(8'h3C, 1'b0, 1'b0, 0);
    n_cmp++; if (dout !== 8'h3C) begin n_fail++; $display("FAIL empty_pop_ptr: dout=%h exp=3c", dout); end
    drain();
    for (int i = 0; i < 40; i++) begin
      send(8'($urandom), 1'b0, 1'b0, 0);
      pop_one();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 5) < 4)
        send(8'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0), $urandom_range(0, 2));
      else
        pop_one();
    end
    drain();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i <= DEPTH; i++) send(8'($urandom), 1'b0, 1'b0, 0);
    @(negedge clk); rx_rdy = 1'b1; rx_data = 8'hC3;
    @(negedge clk);
    n_cmp++; if (rx_rdy_clr !== 1'b1) begin n_fail++; $display("FAIL mid_pre: clr=%b exp=1", rx_rdy_clr); end
    #1 rst = 1'b1;
    #1;
    q.delete(); m_ovr = 1'b0;
    n_cmp++; if (rx_rdy_clr !== 1'b0 || overrun !== 1'b0) begin n_fail++; $display("FAIL mid_async: clr=%b ovr=%b exp 0 0", rx_rdy_clr, overrun); end
    n_cmp++; if (count !== '0 || empty !== 1'b1 || full !== 1'b0 || dout !== 8'h00) begin
      n_fail++; $display("FAIL mid_flags: count=%0d empty=%b full=%b dout=%h", count, empty, full, dout);
    end
    @(negedge clk); rst = 1'b0;
    q.push_back(8'hC3);
    @(negedge clk);
    n_cmp++; if (rx_rdy_clr !== 1'b1 || count !== 5'd1 || dout !== 8'hC3) begin
      n_fail++; $display("FAIL mid_recapture: clr=%b count=%0d dout=%h exp 1 1 c3", rx_rdy_clr, count, dout);
    end
    rx_rdy = 1'b0;
    @(negedge clk);
    drain();
  endtask

  initial begin
    test_reset();
    test_single();
    test_hold_high();
    test_full_overrun();
    test_full_with_pop();
    test_empty_and_wrap();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_drain.md
# uart_rx_drain

Consumer for the UART receiver's ready/clear handshake. Detects a completed byte (`rx_rdy`), captures `rx_data` into an internal FIFO, and pulses `rx_rdy_clr` back to the receiver. Downstream logic reads buffered bytes through a show-ahead FIFO port. Sits between `uart_receiver` and the host-side logic, so bytes are not lost while the host is busy.

## Interface
- `ADDR_W`, default 4: FIFO address width; depth = 2**ADDR_W; legal range 1..8.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `rx_rdy`  in  1  receiver byte-ready; stays high until cleared.
- `rx_data`  in  8  receiver data; valid while `rx_rdy`=1.
- `rx_rdy_clr`  out  1  one-cycle clear pulse to the receiver; registered.
- `rd_en`  in  1  pop request from downstream.
- `dout`  out  8  head of FIFO (show-ahead); 8'h00 when empty.
- `empty`  out  1  FIFO holds no bytes.
- `full`  out  1  FIFO holds 2**ADDR_W bytes.
- `count`  out  ADDR_W+1  bytes currently held.
- `overrun`  out  1  sticky; a byte was dropped because the FIFO was full.
- `clr_overrun`  in  1  synchronous clear of `overrun`.

## Operation
- Handshake FSM states:
  - IDLE: wait for a byte.
  - CLEAR: assert `rx_rdy_clr`.
  - WAIT_LOW: wait for the receiver to drop `rx_rdy`.
- Transitions:
  - IDLE with `rx_rdy`=1 → capture `rx_data`, then go to CLEAR.
  - CLEAR → WAIT_LOW, unconditionally, after one cycle.
  - WAIT_LOW with `rx_rdy`=0 → IDLE. Otherwise stay in WAIT_LOW.
  - A byte is never captured twice for one `rx_rdy` assertion.
- Capture rules:
  - The byte is written if `full`=0, or if `full`=1 and a pop happens in the same cycle.
  - Otherwise the byte is dropped and `overrun` is set. The handshake still completes, so the receiver is always released.
- Pop: `rd_en`=1 and `empty`=0 advances the read pointer. `rd_en` while empty is ignored and has no side effects.
- Pointers are ADDR_W bits and wrap modulo the depth. `count` is the write count minus the pop count and saturates at neither end, because over- and under-flow are blocked.
- Simultaneous write and pop leaves `count` unchanged. This holds at full as well.
- `overrun`: `clr_overrun` takes priority over a new set in the same cycle.
- Reset values: FSM=IDLE, `rx_rdy_clr`=0, pointers=0, `count`=0, `empty`=1, `full`=0, `overrun`=0, `dout`=8'h00. Memory contents are not reset.
- Reset mid-handshake aborts it; `rx_rdy_clr` drops asynchronously. If `rx_rdy` is still high after reset release, that byte is captured again. This is intended.

## Timing
- Let `rx_rdy` rise at cycle N while the FSM is in IDLE:
  - The byte is written at the end of N.
  - `empty`=0, `count` increments, and `dout` shows the byte in N+1.
  - `rx_rdy_clr`=1 in N+1 only.
  - The FSM is in WAIT_LOW from N+2.
- Handshake throughput: at best one byte per 3 cycles, far above the baud rate.
- Pop latency: `rd_en` in cycle M; `dout` shows the next byte (or 8'h00) in M+1.
- `empty`, `full` and `count` are registered. `dout` is combinational from memory and the read pointer.

## Structure
- Package `uart_pkg` holds:
  - `UART_DATA_W`=8.
  - FSM state localparams for IDLE, CLEAR and WAIT_LOW (2-bit encoding).
  - The shared reset convention.
- Sub-module `uart_sync_fifo`: parameterized by ADDR_W and data width, with write/pop/full/empty/count. The FSM and overrun logic stay in `uart_rx_drain`.

## Test plan
- Reset, then drive `rx_rdy` with 8'hA5 held until `rx_rdy_clr` → one `rx_rdy_clr` pulse; `count`=1; `dout`=8'hA5; `empty`=0.
- Hold `rx_rdy` high for 10 cycles after the clear → exactly one byte is captured and the FSM stays in WAIT_LOW.
- Write 16 bytes 8'h00..8'h0F with ADDR_W=4, then a 17th byte 8'hFF → `full`=1, `overrun`=1, and popping 16 times returns 00..0F in order. Then pulse `clr_overrun` → `overrun`=0.
- With the FIFO full, capture 8'h55 in the same cycle as `rd_en` → `count` stays 16, `overrun`=0, and 8'h55 is the last byte popped.
- Pop while empty → `count`=0, `dout`=8'h00, no pointer movement. Then 40 write/pop pairs → verify pointer wrap and data order.
- Assert `rst` during CLEAR → `rx_rdy_clr` drops immediately and all flags take their reset values. With `rx_rdy` still high, that byte is recaptured after reset release.
